// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbitrated selector.
package rr_arb_pkg;

  // Arbitration mode encodings for the RR_MODE parameter.
  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;

  // Ceiling log2 for n >= 1; returns 0 for n == 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Channel-index width, never narrower than one bit.
  function automatic int ch_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Arbiter: picks the first requester at or above the start index, wrapping
// modulo NUM_CH. Owns the round-robin pointer.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int  NUM_CH  = 4,
  parameter int  RR_MODE = RR_ROUND,
  localparam int CH_W    = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_d;
  logic [CH_W-1:0] start;
  logic [CH_W:0]   sum;
  logic [CH_W-1:0] idx;
  logic            found;

  assign start = (RR_MODE == RR_ROUND) ? ptr_q : '0;

  // Scan upward from the start index; the first requester found wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no
    // path leaves a value unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, start} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      idx = sum[CH_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Pointer moves to the slot after the winner on every accepted transfer;
  // explicit compare keeps the wrap correct for non-power-of-two NUM_CH.
  always_comb begin
    ptr_d = ptr_q;
    if (RR_MODE != RR_ROUND) begin
      ptr_d = '0;
    end else if (advance) begin
      ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Arbitrated N:1 selector with a registered valid/ready output stage.
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter int  WIDTH   = 8,
  parameter int  NUM_CH  = 4,
  parameter int  RR_MODE = RR_ROUND,
  localparam int CH_W    = ch_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready
);

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              can_load;
  logic              xfer;
  logic [WIDTH-1:0]  sel_data;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [CH_W-1:0]   out_ch_q,    out_ch_d;

  rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The output slot can take a word when empty or being drained this cycle.
  assign can_load = !out_valid_q || out_ready;
  assign in_ready = grant & {NUM_CH{can_load}};
  assign xfer     = |(in_valid & in_ready);
  assign sel_data = in_data[grant_idx*WIDTH +: WIDTH];

  // Load on transfer (even while draining, so no bubble); clear valid on a
  // pure drain; data and channel hold otherwise.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; reset drops any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench: round-robin 4-ch, fixed-priority 4-ch and round-robin 3-ch.
module tb_rr_arb_mux;
  import rr_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 4 ch, 8 bit, round-robin
  logic [3:0]  v_a = '0, ir_a;
  logic [31:0] d_a = '0;
  logic        ov_a, or_a = 1'b0;
  logic [7:0]  od_a;
  logic [1:0]  oc_a;

  // Instance B: 4 ch, 8 bit, fixed priority
  logic [3:0]  v_b = '0, ir_b;
  logic [31:0] d_b = '0;
  logic        ov_b, or_b = 1'b0;
  logic [7:0]  od_b;
  logic [1:0]  oc_b;

  // Instance C: 3 ch, 16 bit, round-robin
  logic [2:0]  v_c = '0, ir_c;
  logic [47:0] d_c = '0;
  logic        ov_c, or_c = 1'b0;
  logic [15:0] od_c;
  logic [1:0]  oc_c;

  int total = 0;
  int bad   = 0;

  rr_arb_mux #(.WIDTH(8), .NUM_CH(4), .RR_MODE(RR_ROUND)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(v_a), .in_data(d_a), .in_ready(ir_a),
    .out_valid(ov_a), .out_data(od_a), .out_ch(oc_a), .out_ready(or_a));

  rr_arb_mux #(.WIDTH(8), .NUM_CH(4), .RR_MODE(RR_FIXED)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(v_b), .in_data(d_b), .in_ready(ir_b),
    .out_valid(ov_b), .out_data(od_b), .out_ch(oc_b), .out_ready(or_b));

  rr_arb_mux #(.WIDTH(16), .NUM_CH(3), .RR_MODE(RR_ROUND)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(v_c), .in_data(d_c), .in_ready(ir_c),
    .out_valid(ov_c), .out_data(od_c), .out_ch(oc_c), .out_ready(or_c));

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    d_a = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    d_b = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    d_c = {16'hC002, 16'hC001, 16'hC000};
    #3;
    total++;
    if ({ov_a, oc_a, od_a} !== 11'd0) begin
      bad++; $display("FAIL reset_a: got v=%b ch=%0d d=%h want 0/0/00", ov_a, oc_a, od_a);
    end
    total++;
    if ({ov_b, oc_b, od_b, ov_c, oc_c, od_c} !== 30'd0) begin
      bad++; $display("FAIL reset_bc: got b=%b/%0d/%h c=%b/%0d/%h want zeros",
                      ov_b, oc_b, od_b, ov_c, oc_c, od_c);
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    total++;
    if (ov_a !== 1'b0 || ir_a !== 4'b0000) begin
      bad++; $display("FAIL idle_after_reset: got v=%b rdy=%b want 0/0000", ov_a, ir_a);
    end
    v_a = 4'hF; or_a = 1'b1;
    #1;
    total++;
    if (ir_a !== 4'b0001) begin
      bad++; $display("FAIL first_grant: got rdy=%b want 0001", ir_a);
    end
  endtask

  task automatic test_rr_fairness();
    logic [1:0] e_c;
    logic [3:0] e_r;
    for (int i = 0; i < 8; i++) begin
      step();
      e_c = 2'(i % 4);
      total++;
      if (ov_a !== 1'b1 || oc_a !== e_c || od_a !== 8'hA0 + 8'(e_c)) begin
        bad++; $display("FAIL rr_seq[%0d]: got v=%b ch=%0d d=%h want 1/%0d/%h",
                        i, ov_a, oc_a, od_a, e_c, 8'hA0 + 8'(e_c));
      end
      e_r = 4'(1 << ((i + 1) % 4));
      total++;
      if (ir_a !== e_r) begin
        bad++; $display("FAIL rr_ready[%0d]: got %b want %b", i, ir_a, e_r);
      end
    end
  endtask

  task automatic test_backpressure();
    or_a = 1'b0;
    #1;
    total++;
    if (ir_a !== 4'b0000) begin
      bad++; $display("FAIL bp_ready_now: got %b want 0000", ir_a);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (ov_a !== 1'b1 || oc_a !== 2'd3 || od_a !== 8'hA3 || ir_a !== 4'b0000) begin
        bad++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h rdy=%b want 1/3/a3/0000",
                        i, ov_a, oc_a, od_a, ir_a);
      end
    end
    or_a = 1'b1;
    #1;
    total++;
    if (ir_a !== 4'b0001) begin
      bad++; $display("FAIL bp_release_ready: got %b want 0001", ir_a);
    end
    step();
    total++;
    if (ov_a !== 1'b1 || oc_a !== 2'd0 || od_a !== 8'hA0) begin
      bad++; $display("FAIL bp_no_bubble: got v=%b ch=%0d d=%h want 1/0/a0", ov_a, oc_a, od_a);
    end
  endtask

  task automatic test_idle_drain();
    v_a = 4'h0;
    step();
    total++;
    if (ov_a !== 1'b0 || oc_a !== 2'd0 || od_a !== 8'hA0) begin
      bad++; $display("FAIL drain: got v=%b ch=%0d d=%h want 0/0/a0", ov_a, oc_a, od_a);
    end
    step();
    total++;
    if (ov_a !== 1'b0 || od_a !== 8'hA0) begin
      bad++; $display("FAIL drain_hold: got v=%b d=%h want 0/a0", ov_a, od_a);
    end
    v_a = 4'hF;
    #1;
    total++;
    if (ir_a !== 4'b0010) begin
      bad++; $display("FAIL drain_ptr_kept: got rdy=%b want 0010", ir_a);
    end
    step();
    total++;
    if (ov_a !== 1'b1 || oc_a !== 2'd1 || od_a !== 8'hA1) begin
      bad++; $display("FAIL drain_reload: got v=%b ch=%0d d=%h want 1/1/a1", ov_a, oc_a, od_a);
    end
  endtask

  task automatic test_single_and_wrap();
    v_a = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ir_a !== 4'b0100) begin
        bad++; $display("FAIL single_ready[%0d]: got %b want 0100", i, ir_a);
      end
      step();
      total++;
      if (ov_a !== 1'b1 || oc_a !== 2'd2 || od_a !== 8'hA2) begin
        bad++; $display("FAIL single_out[%0d]: got v=%b ch=%0d d=%h want 1/2/a2", i, ov_a, oc_a, od_a);
      end
    end
    v_a = 4'b1001;
    #1;
    total++;
    if (ir_a !== 4'b1000) begin
      bad++; $display("FAIL wrap_ready: got %b want 1000", ir_a);
    end
    step();
    total++;
    if (oc_a !== 2'd3 || od_a !== 8'hA3 || ir_a !== 4'b0001) begin
      bad++; $display("FAIL wrap_ch3: got ch=%0d d=%h rdy=%b want 3/a3/0001", oc_a, od_a, ir_a);
    end
    step();
    total++;
    if (oc_a !== 2'd0 || od_a !== 8'hA0) begin
      bad++; $display("FAIL wrap_ch0: got ch=%0d d=%h want 0/a0", oc_a, od_a);
    end
  endtask

  task automatic test_reset_mid();
    v_a = 4'hF; or_a = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ov_a, oc_a, od_a} !== 11'd0) begin
      bad++; $display("FAIL reset_mid_async: got v=%b ch=%0d d=%h want 0/0/00", ov_a, oc_a, od_a);
    end
    step();
    step();
    total++;
    if ({ov_a, oc_a, od_a} !== 11'd0) begin
      bad++; $display("FAIL reset_mid_hold: got v=%b ch=%0d d=%h want 0/0/00", ov_a, oc_a, od_a);
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    total++;
    if (ir_a !== 4'b0001) begin
      bad++; $display("FAIL reset_mid_ptr: got rdy=%b want 0001", ir_a);
    end
    step();
    total++;
    if (ov_a !== 1'b1 || oc_a !== 2'd0 || od_a !== 8'hA0) begin
      bad++; $display("FAIL reset_mid_first: got v=%b ch=%0d d=%h want 1/0/a0", ov_a, oc_a, od_a);
    end
  endtask

  task automatic test_fixed();
    v_b = 4'b1110; or_b = 1'b1;
    #1;
    total++;
    if (ir_b !== 4'b0010) begin
      bad++; $display("FAIL fx_ready0: got %b want 0010", ir_b);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (ov_b !== 1'b1 || oc_b !== 2'd1 || od_b !== 8'hB1 || ir_b !== 4'b0010) begin
        bad++; $display("FAIL fx_ch1[%0d]: got v=%b ch=%0d d=%h rdy=%b want 1/1/b1/0010",
                        i, ov_b, oc_b, od_b, ir_b);
      end
    end
    v_b = 4'b1100;
    #1;
    total++;
    if (ir_b !== 4'b0100) begin
      bad++; $display("FAIL fx_drop1_ready: got %b want 0100", ir_b);
    end
    step();
    total++;
    if (oc_b !== 2'd2 || od_b !== 8'hB2) begin
      bad++; $display("FAIL fx_drop1_out: got ch=%0d d=%h want 2/b2", oc_b, od_b);
    end
    v_b = 4'hF;
    step();
    step();
    total++;
    if (oc_b !== 2'd0 || od_b !== 8'hB0 || ir_b !== 4'b0001) begin
      bad++; $display("FAIL fx_all: got ch=%0d d=%h rdy=%b want 0/b0/0001", oc_b, od_b, ir_b);
    end
  endtask

  task automatic test_nonpow2();
    logic [1:0] e_c;
    logic [2:0] e_r;
    v_c = 3'b111; or_c = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      e_c = 2'(i % 3);
      total++;
      if (ov_c !== 1'b1 || oc_c !== e_c || od_c !== 16'hC000 + 16'(e_c)) begin
        bad++; $display("FAIL np2_seq[%0d]: got v=%b ch=%0d d=%h want 1/%0d/%h",
                        i, ov_c, oc_c, od_c, e_c, 16'hC000 + 16'(e_c));
      end
      e_r = 3'(1 << ((i + 1) % 3));
      total++;
      if (ir_c !== e_r) begin
        bad++; $display("FAIL np2_ready[%0d]: got %b want %b", i, ir_c, e_r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_backpressure();
    test_idle_drain();
    test_single_and_wrap();
    test_reset_mid();
    test_fixed();
    test_nonpow2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
